// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline through div_stall and returns quotient on lo_out and remainder on hi_out.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             div_stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DIVZERO = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             rv_q, rv_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return cond_neg(v, sgn && v[WIDTH-1]);
    endfunction

    assign accept    = (state_q == IDLE) && div_req && !cancel;
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring step: the WIDTH+1 bit trial difference decides the quotient bit.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quo = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (div_req) state_d = (opb == '0) ? DIVZERO : RUN;
                RUN:     if (last_step) state_d = DONE;
                DIVZERO: state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        div_stall = !cancel && (((state_q == IDLE) && div_req) ||
                                (state_q == RUN) || (state_q == DIVZERO));
    end

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rv_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Divide-by-zero keeps the raw dividend for the remainder result.
                    dvd_d     = (opb == '0) ? opa : abs_val(opa, div_signed);
                    dvs_d     = abs_val(opb, div_signed);
                    neg_quo_d = div_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    neg_rem_d = div_signed && opa[WIDTH-1];
                    rem_d     = '0;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step && !cancel) begin
                    lo_d = cond_neg(step_quo, neg_quo_q);
                    hi_d = cond_neg(step_rem, neg_rem_q);
                    rv_d = 1'b1;
                end
            end
            DIVZERO: begin
                if (!cancel) begin
                    lo_d = '1;
                    hi_d = dvd_q;
                    rv_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            rv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            rv_q  <= rv_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        dvd_q     <= dvd_d;
        dvs_q     <= dvs_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign result_valid = rv_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected quotient/remainder queued at request,
// compared when result_valid pulses; stall length, latency, cancel and reset checked inline.
module tb_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_req;
    logic         div_signed;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cancel;
    logic         div_stall;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_lo_q[$];
    logic [W-1:0] exp_hi_q[$];

    div_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .opa          (opa),
        .opb          (opb),
        .cancel       (cancel),
        .div_stall    (div_stall),
        .busy         (busy),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint sa, sb, q, r;
        if (b == 0) begin
            lo = '1;
            hi = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Scoreboard: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_lo_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("lo", lo_out, exp_lo_q.pop_front());
                check("hi", hi_out, exp_hi_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [W-1:0] elo, input logic [W-1:0] ehi,
                           input int exp_rv, input bit hold);
        int stall_cnt;
        bit got;
        stall_cnt  = 0;
        got        = 1'b0;
        div_req    = 1'b1;
        opa        = a;
        opb        = b;
        div_signed = s;
        exp_lo_q.push_back(elo);
        exp_hi_q.push_back(ehi);
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (c == 0) check("busy_at_accept", busy, 0);
            if (result_valid) begin
                check("rv_cycle", c, exp_rv);
                check("stall_in_done", div_stall, 0);
                got = 1'b1;
            end else begin
                if (div_stall) stall_cnt++;
                step();
                if (c == 0) begin
                    opa        = $urandom;
                    opb        = $urandom;
                    div_signed = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got) check("rv_timeout", 0, 1);
        check("stall_cycles", stall_cnt, exp_rv);
        if (!hold) div_req = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb, rlo, rhi;
        logic         rs;

        rst        = 1'b1;
        div_req    = 1'b0;
        div_signed = 1'b0;
        opa        = '0;
        opb        = '0;
        cancel     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rv", result_valid, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", div_stall, 0);
        rst = 1'b0;

        run_div(32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 33, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0);
        run_div(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 2, 1'b0);

        // Cancel in cycle 10 of a 100/7 divide.
        div_req    = 1'b1;
        opa        = 32'd100;
        opb        = 32'd7;
        div_signed = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0) check("cancel_stall_c0", div_stall, 1);
            step();
        end
        cancel  = 1'b1;
        div_req = 1'b0;
        #1;
        check("cancel_stall", div_stall, 0);
        check("cancel_rv", result_valid, 0);
        step();
        cancel = 1'b0;
        #1;
        check("cancel_busy", busy, 0);
        check("cancel_hi_hold", hi_out, 32'h1234);
        check("cancel_lo_hold", lo_out, 32'hFFFF_FFFF);
        repeat (3) step();
        check("cancel_idle", busy, 0);
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);

        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rlo, rhi);
            run_div(ra, rb, rs, rlo, rhi, 33, 1'b0);
        end

        run_div(32'd15, 32'd4, 1'b0, 32'd3, 32'd3, 33, 1'b1);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

        // Reset in the middle of RUN.
        div_req    = 1'b1;
        opa        = 32'd15;
        opb        = 32'd4;
        div_signed = 1'b0;
        repeat (5) step();
        div_req = 1'b0;
        rst     = 1'b1;
        step();
        check("midrst_rv", result_valid, 0);
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_stall", div_stall, 0);
        rst = 1'b0;
        repeat (2) step();

        check("queue_empty", exp_lo_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
